// File: rtl/uvma_axi_pkg.sv
// uvma_axi_pkg: shared error-flag bit positions and error vector type for the AXI write tracker
// Exports: ERR_* bit indices into the error vector, ERR_W vector width, err_t vector type
package uvma_axi_pkg;
   localparam int ERR_OVERFLOW      = 0;
   localparam int ERR_W_NO_AW       = 1;
   localparam int ERR_WLAST_EARLY   = 2;
   localparam int ERR_WLAST_MISSING = 3;
   localparam int ERR_B_UNEXPECTED  = 4;
   localparam int ERR_W             = 5;
   typedef logic [ERR_W-1:0] err_t;
endpackage

// File: rtl/uvma_axi_wr_tracker_fifo.sv
// uvma_axi_wr_tracker_fifo: order FIFO holding {table index, burst length} of writes awaiting W data
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2)
// Ports: clk, rst_n (async active-low); push_i/data_i write; pop_i retires data_o (head);
//   full_o/empty_o occupancy flags
module uvma_axi_wr_tracker_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   // Storage is not reset: clearing the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end
   assign data_o  = mem_q[rd_q];
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
endmodule

// File: rtl/uvma_axi_wr_tracker.sv
// uvma_axi_wr_tracker: passive AXI write-channel tracker checking AW/W/B ordering and responses
// Parameters: ID_WIDTH (AW/B id width), DEPTH (max outstanding writes, power of 2, >= 2)
// Ports: clk, rst_n (async active-low); aw_*, w_*, b_* observed channel signals;
//   err_clr clears err_sticky; outstanding = allocated table entries;
//   err_pulse = one-cycle error flags, err_sticky = accumulated flags; stat_* = handshake counters
// Build option: UVMA_AXI_WR_TRACKER_STATS_EN enables stat_* counters, otherwise they read 0
module uvma_axi_wr_tracker
   import uvma_axi_pkg::*;
#(
   parameter int ID_WIDTH = 4,
   parameter int DEPTH    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       aw_valid,
   input  logic                       aw_ready,
   input  logic [ID_WIDTH-1:0]        aw_id,
   input  logic [7:0]                 aw_len,
   input  logic                       w_valid,
   input  logic                       w_ready,
   input  logic                       w_last,
   input  logic                       b_valid,
   input  logic                       b_ready,
   input  logic [ID_WIDTH-1:0]        b_id,
   input  logic                       err_clr,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output err_t                       err_pulse,
   output err_t                       err_sticky,
   output logic [31:0]                stat_aw,
   output logic [31:0]                stat_w,
   output logic [31:0]                stat_b
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int FW = IW + 8;
   logic [DEPTH-1:0]    valid_q, valid_d, wdone_q, wdone_d;
   logic [ID_WIDTH-1:0] id_q [DEPTH];
   logic [7:0]          cnt_q, cnt_d, head_len;
   logic                miss_q, miss_d;
   logic [CW-1:0]       outstanding_q, outstanding_d;
   err_t                err_q, err_d, sticky_q, sticky_d;
   logic                aw_hs, w_hs, b_hs, free_ok, b_ok, alloc, b_free, w_act, close, push, pop;
   logic                fifo_full, fifo_empty;
   logic [IW-1:0]       free_idx, b_idx, head_idx;
   logic [FW-1:0]       fifo_dout;
   assign aw_hs = aw_valid && aw_ready;
   assign w_hs  = w_valid && w_ready;
   assign b_hs  = b_valid && b_ready;
   // Descending scan so the lowest matching index wins.
   always_comb begin
      free_ok  = 1'b0;
      free_idx = '0;
      b_ok     = 1'b0;
      b_idx    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_ok  = 1'b1;
            free_idx = IW'(i);
         end
         if (valid_q[i] && wdone_q[i] && id_q[i] == b_id) begin
            b_ok  = 1'b1;
            b_idx = IW'(i);
         end
      end
   end
   assign alloc  = aw_hs && free_ok;
   assign b_free = b_hs && b_ok;
   // With the FIFO empty, a same-cycle AW acts as the head (bypass).
   assign w_act    = w_hs && (!fifo_empty || alloc);
   assign head_idx = fifo_empty ? free_idx : fifo_dout[FW-1:8];
   assign head_len = fifo_empty ? aw_len : fifo_dout[7:0];
   assign close    = w_act && w_last;
   assign push     = alloc && !fifo_full && !(fifo_empty && close);
   assign pop      = close && !fifo_empty;
   // Frees and allocations use the registered table, so a slot freed by B is only reusable next cycle.
   always_comb begin
      valid_d = valid_q;
      wdone_d = wdone_q;
      if (alloc) valid_d[free_idx] = 1'b1;
      if (close) wdone_d[head_idx] = 1'b1;
      if (b_free) begin
         valid_d[b_idx] = 1'b0;
         wdone_d[b_idx] = 1'b0;
      end
   end
   always_comb begin
      err_d                    = '0;
      err_d[ERR_OVERFLOW]      = aw_hs && !free_ok;
      err_d[ERR_W_NO_AW]       = w_hs && !w_act;
      err_d[ERR_WLAST_EARLY]   = close && cnt_q != head_len;
      err_d[ERR_WLAST_MISSING] = w_act && !w_last && cnt_q == head_len && !miss_q;
      err_d[ERR_B_UNEXPECTED]  = b_hs && !b_ok;
   end
   // Beat count saturates at the burst length; miss_q limits the missing-last flag to once per burst.
   assign cnt_d         = close ? 8'd0 : (w_act && cnt_q != head_len) ? cnt_q + 8'd1 : cnt_q;
   assign miss_d        = !close && (miss_q || err_d[ERR_WLAST_MISSING]);
   assign outstanding_d = outstanding_q + CW'(alloc) - CW'(b_free);
   assign sticky_d      = (err_clr ? '0 : sticky_q) | err_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= '0;
         wdone_q       <= '0;
         cnt_q         <= '0;
         miss_q        <= 1'b0;
         outstanding_q <= '0;
         err_q         <= '0;
         sticky_q      <= '0;
         for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
      end else begin
         valid_q       <= valid_d;
         wdone_q       <= wdone_d;
         cnt_q         <= cnt_d;
         miss_q        <= miss_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         sticky_q      <= sticky_d;
         if (alloc) id_q[free_idx] <= aw_id;
      end
   end
   uvma_axi_wr_tracker_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .pop_i  (pop),
      .data_i ({free_idx, aw_len}),
      .data_o (fifo_dout),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );
   assign outstanding = outstanding_q;
   assign err_pulse   = err_q;
   assign err_sticky  = sticky_q;
`ifdef UVMA_AXI_WR_TRACKER_STATS_EN
   logic [31:0] stat_aw_q, stat_w_q, stat_b_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_aw_q <= '0;
         stat_w_q  <= '0;
         stat_b_q  <= '0;
      end else begin
         stat_aw_q <= stat_aw_q + 32'(aw_hs);
         stat_w_q  <= stat_w_q + 32'(w_hs);
         stat_b_q  <= stat_b_q + 32'(b_hs);
      end
   end
   assign stat_aw = stat_aw_q;
   assign stat_w  = stat_w_q;
   assign stat_b  = stat_b_q;
`else
   assign stat_aw = '0;
   assign stat_w  = '0;
   assign stat_b  = '0;
`endif
endmodule

// File: tb/tb_uvma_axi_wr_tracker.sv
// tb_uvma_axi_wr_tracker: randomized scoreboard bench for uvma_axi_wr_tracker against a queue-based model
module tb_uvma_axi_wr_tracker;
   localparam int DEPTH = 8;
   typedef struct {
      logic [3:0] id;
      int         len;
   } burst_t;
   typedef struct {
      logic [4:0] err;
      int         outs;
      logic [4:0] sticky;
   } exp_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        aw_valid = 1'b0, aw_ready = 1'b0, w_valid = 1'b0, w_ready = 1'b0, w_last = 1'b0;
   logic        b_valid = 1'b0, b_ready = 1'b0, err_clr = 1'b0;
   logic [3:0]  aw_id = '0, b_id = '0;
   logic [7:0]  aw_len = '0;
   logic [3:0]  outstanding;
   logic [4:0]  err_pulse, err_sticky;
   logic [31:0] stat_aw, stat_w, stat_b;
   int          total = 0, bad = 0, n_aw = 0, n_w = 0, n_b = 0, beats = 0;
   burst_t      pend[$];
   logic [3:0]  done_q[$];
   logic [4:0]  m_sticky = '0;
   exp_t        exp_q[$];
   exp_t        mon_e;

   uvma_axi_wr_tracker #(.ID_WIDTH(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_len(aw_len),
      .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id),
      .err_clr(err_clr), .outstanding(outstanding), .err_pulse(err_pulse), .err_sticky(err_sticky),
      .stat_aw(stat_aw), .stat_w(stat_w), .stat_b(stat_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // A non-handshake cycle still shows valid-only or ready-only activity.
   task automatic drive_hs(input bit hs, output logic v, output logic r);
      int k;
      k = $urandom_range(0, 2);
      v = hs || k == 1;
      r = hs || k == 2;
   endtask

   task automatic cyc(input bit aw, input int aid, input int alen, input bit w, input bit wl,
                      input bit b, input int bid, input bit clr = 1'b0);
      exp_t e;
      int   idx;
      bit   full;
      @(negedge clk);
      drive_hs(aw, aw_valid, aw_ready);
      drive_hs(w, w_valid, w_ready);
      drive_hs(b, b_valid, b_ready);
      aw_id   = 4'(aid);
      aw_len  = 8'(alen);
      w_last  = wl;
      b_id    = 4'(bid);
      err_clr = clr;
      n_aw += int'(aw);
      n_w  += int'(w);
      n_b  += int'(b);
      e.err = '0;
      full  = (pend.size() + done_q.size()) == DEPTH;
      if (b) begin
         idx = -1;
         foreach (done_q[i]) if (idx < 0 && done_q[i] == 4'(bid)) idx = i;
         if (idx < 0) e.err[4] = 1'b1;
         else done_q.delete(idx);
      end
      if (aw) begin
         if (full) e.err[0] = 1'b1;
         else pend.push_back('{4'(aid), alen});
      end
      if (w) begin
         if (pend.size() == 0) e.err[1] = 1'b1;
         else if (wl) begin
            if (beats < pend[0].len) e.err[2] = 1'b1;
            done_q.push_back(pend[0].id);
            void'(pend.pop_front());
            beats = 0;
         end else begin
            if (beats == pend[0].len) e.err[3] = 1'b1;
            beats++;
         end
      end
      m_sticky = (clr ? 5'b0 : m_sticky) | e.err;
      e.sticky = m_sticky;
      e.outs   = pend.size() + done_q.size();
      exp_q.push_back(e);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic post();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      {aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready, err_clr} = '0;
      pend.delete();
      done_q.delete();
      beats = 0;
      m_sticky = '0;
      n_aw = 0;
      n_w = 0;
      n_b = 0;
      #1;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_sticky", err_sticky, 0);
      chk("rst_stats", {stat_aw, stat_w, stat_b}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst_n) exp_q.delete();
      else if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         total++;
         if (err_pulse !== mon_e.err || outstanding !== 4'(mon_e.outs) || err_sticky !== mon_e.sticky) begin
            bad++;
            $display("FAIL scoreboard @%0t: got err_pulse=%b outstanding=%0d err_sticky=%b want err_pulse=%b outstanding=%0d err_sticky=%b",
                     $time, err_pulse, outstanding, err_sticky, mon_e.err, mon_e.outs, mon_e.sticky);
         end
      end
   end

   initial begin
      do_reset();
      // Clean write: id 3, four beats, then its response
      cyc(1, 3, 3, 0, 0, 0, 0);
      post();
      chk("basic_out_1", outstanding, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, i == 3, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 3);
      post();
      chk("basic_out_0", outstanding, 0);
      chk("basic_sticky", err_sticky, 0);
      // Fill the table, then overflow
      for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0, 0, 0);
      cyc(1, 8, 0, 0, 0, 0, 0);
      post();
      chk("ovf_pulse", err_pulse, 5'b00001);
      chk("ovf_out", outstanding, 8);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, 0, 0);
      // Slot freed by B is not reusable by a same-cycle AW
      cyc(1, 9, 0, 0, 0, 1, 0);
      post();
      chk("free_reuse_ovf", err_pulse, 5'b00001);
      cyc(1, 9, 0, 1, 1, 0, 0);
      for (int i = 1; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, i);
      cyc(0, 0, 0, 0, 0, 1, 9);
      post();
      chk("drained_out", outstanding, 0);
      // Early last, then missing last reported once
      cyc(1, 1, 3, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      post();
      chk("wlast_early", err_pulse, 5'b00100);
      cyc(0, 0, 0, 0, 0, 1, 1);
      cyc(1, 2, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      post();
      chk("wlast_missing", err_pulse, 5'b01000);
      cyc(0, 0, 0, 1, 1, 0, 0);
      post();
      chk("wlast_late_close", err_pulse, 5'b00000);
      cyc(0, 0, 0, 0, 0, 1, 2);
      // Orphan W, then AW+W bypass, then same-cycle wdone not matched by B
      cyc(0, 0, 0, 1, 1, 0, 0);
      post();
      chk("w_no_aw", err_pulse, 5'b00010);
      cyc(1, 4, 0, 1, 1, 0, 0);
      post();
      chk("bypass_ok", err_pulse, 5'b00000);
      cyc(1, 6, 0, 1, 1, 1, 6);
      post();
      chk("b_same_cycle_wdone", err_pulse, 5'b10000);
      cyc(0, 0, 0, 0, 0, 1, 6);
      cyc(0, 0, 0, 0, 0, 1, 4);
      post();
      chk("bypass_freed", outstanding, 0);
      // Unexpected B and sticky clear behaviour
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 5);
      post();
      chk("b_unexp_sticky", err_sticky, 5'b10000);
      cyc(0, 0, 0, 0, 0, 1, 5, 1);
      post();
      chk("clr_vs_new", err_sticky, 5'b10000);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      post();
      chk("clr_done", err_sticky, 5'b00000);
      // Reset in the middle of a burst, then a clean transaction
      cyc(1, 7, 3, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      do_reset();
      cyc(1, 2, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 2);
      post();
      chk("post_reset_clean", err_sticky, 5'b00000);
      // Random traffic
      for (int n = 0; n < 1500; n++)
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 15) == 0);
      idle();
      post();
      chk("sb_drained", exp_q.size(), 0);
`ifdef UVMA_AXI_WR_TRACKER_STATS_EN
      chk("stat_aw", stat_aw, n_aw);
      chk("stat_w", stat_w, n_w);
      chk("stat_b", stat_b, n_b);
`else
      chk("stat_aw_off", stat_aw, 0);
      chk("stat_w_off", stat_w, 0);
      chk("stat_b_off", stat_b, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
